// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and defaults for the UART TX push-port scheduler
package uart_sched_pkg;

   typedef enum logic [0:0] {
      SCHED_IDLE  = 1'b0,
      SCHED_BURST = 1'b1
   } sched_state_e;

   localparam int SCHED_NUM_REQ    = 4;
   localparam int SCHED_DATA_WIDTH = 8;
   localparam int SCHED_TIMEOUT    = 255;

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational round-robin pick starting just after the pointer
module uart_rr_arb #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] ptr_i,
   output logic [ID_WIDTH-1:0] idx_o,
   output logic                found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      // The pointer itself is scanned last, so the previous owner has lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
            found_o = 1'b1;
            idx_o   = ID_WIDTH'((int'(ptr_i) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - frame-atomic round-robin scheduler for the UART TX FIFO push port
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ    = SCHED_NUM_REQ,
   parameter int DATA_WIDTH = SCHED_DATA_WIDTH,
   parameter int TIMEOUT    = SCHED_TIMEOUT,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          en_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          push_o,
   output logic [DATA_WIDTH-1:0]         dat_o,
   input  logic                          full_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          busy_o,
   output logic                          timeout_o,
   output logic [ID_WIDTH-1:0]           timeout_id_o
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   sched_state_e        state_q, state_d;
   logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_d;
   logic [ID_WIDTH-1:0] last_id_q, last_id_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic [ID_WIDTH-1:0] timeout_id_q, timeout_id_d;

   logic [ID_WIDTH-1:0] arb_idx;
   logic                arb_found;

   uart_rr_arb #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req_i   (req_valid_i),
      .ptr_i   (last_id_q),
      .idx_o   (arb_idx),
      .found_o (arb_found)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= SCHED_IDLE;
         gnt_id_q     <= '0;
         last_id_q    <= ID_WIDTH'(NUM_REQ - 1);
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_id_q     <= gnt_id_d;
         last_id_q    <= last_id_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
         timeout_id_q <= timeout_id_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      gnt_id_d     = gnt_id_q;
      last_id_d    = last_id_q;
      cnt_d        = cnt_q;
      timeout_d    = 1'b0;
      timeout_id_d = timeout_id_q;
      req_ready_o  = '0;
      push_o       = 1'b0;
      dat_o        = '0;
      gnt_o        = '0;

      unique case (state_q)
         SCHED_IDLE: begin
            if (en_i && arb_found) begin
               gnt_id_d = arb_idx;
               cnt_d    = '0;
               state_d  = SCHED_BURST;
            end
         end
         SCHED_BURST: begin
            gnt_o[gnt_id_q] = 1'b1;
            dat_o           = req_data_i[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
            // A stalled owner is revoked without accepting anything further from it.
            if (cnt_q == CNT_MAX) begin
               timeout_d    = 1'b1;
               timeout_id_d = gnt_id_q;
               last_id_d    = gnt_id_q;
               cnt_d        = '0;
               state_d      = SCHED_IDLE;
            end else begin
               req_ready_o[gnt_id_q] = ~full_i;
               push_o                = req_valid_i[gnt_id_q] & ~full_i;
               if (push_o) begin
                  cnt_d = '0;
                  if (req_last_i[gnt_id_q]) begin
                     last_id_d = gnt_id_q;
                     state_d   = SCHED_IDLE;
                  end
               end else if (!req_valid_i[gnt_id_q]) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = SCHED_IDLE;
      endcase
   end

   assign busy_o       = (state_q == SCHED_BURST);
   assign timeout_o    = timeout_q;
   assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - table-driven bench for uart_tx_sched with TIMEOUT=4
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  valid;
   logic [31:0] data;
   logic [3:0]  last;
   logic [3:0]  ready;
   logic        push;
   logic [7:0]  dat;
   logic        full;
   logic [3:0]  gnt;
   logic        busy;
   logic        tout;
   logic [1:0]  tout_id;

   int n_checks = 0;
   int n_err    = 0;

   uart_tx_sched #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .TIMEOUT    (4)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .en_i         (en),
      .req_valid_i  (valid),
      .req_data_i   (data),
      .req_last_i   (last),
      .req_ready_o  (ready),
      .push_o       (push),
      .dat_o        (dat),
      .full_i       (full),
      .gnt_o        (gnt),
      .busy_o       (busy),
      .timeout_o    (tout),
      .timeout_id_o (tout_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        full;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic        push;
      logic [7:0]  dat;
      logic [3:0]  rdy;
      logic        busy;
      logic        to;
      logic [1:0]  toid;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic e, input logic f, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic [3:0] g, input logic p, input logic [7:0] dt,
                      input logic [3:0] r, input logic b, input logic t, input logic [1:0] ti);
      vec_t x;
      x.en = e; x.full = f; x.valid = v; x.last = l; x.data = d;
      x.gnt = g; x.push = p; x.dat = dt; x.rdy = r; x.busy = b; x.to = t; x.toid = ti;
      vecs.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic p, input logic [7:0] dt,
                          input logic [3:0] r, input logic b, input logic t, input logic [1:0] ti);
      chk({tag, " gnt"},   32'(gnt),     32'(g));
      chk({tag, " push"},  32'(push),    32'(p));
      chk({tag, " dat"},   32'(dat),     32'(dt));
      chk({tag, " ready"}, 32'(ready),   32'(r));
      chk({tag, " busy"},  32'(busy),    32'(b));
      chk({tag, " tout"},  32'(tout),    32'(t));
      chk({tag, " toid"},  32'(tout_id), 32'(ti));
   endtask

   initial begin
      // order 0,2,3 from reset pointer; one idle cycle between frames
      add(1,0,4'b1101,4'b0000,32'h40300010, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      add(1,0,4'b1101,4'b0000,32'h40300010, 4'b0001,1,8'h10,4'b0001,1,0,2'd0);
      add(1,0,4'b1101,4'b0001,32'h40300011, 4'b0001,1,8'h11,4'b0001,1,0,2'd0);
      add(1,0,4'b1100,4'b0000,32'h40300000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      add(1,0,4'b1100,4'b0000,32'h40300000, 4'b0100,1,8'h30,4'b0100,1,0,2'd0);
      add(1,0,4'b1100,4'b0100,32'h40310000, 4'b0100,1,8'h31,4'b0100,1,0,2'd0);
      add(1,0,4'b1000,4'b0000,32'h40000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      add(1,0,4'b1000,4'b0000,32'h40000000, 4'b1000,1,8'h40,4'b1000,1,0,2'd0);
      add(1,0,4'b1000,4'b1000,32'h41000000, 4'b1000,1,8'h41,4'b1000,1,0,2'd0);
      add(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      // req1 three-byte frame
      add(1,0,4'b0010,4'b0000,32'h00004100, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      add(1,0,4'b0010,4'b0000,32'h00004100, 4'b0010,1,8'h41,4'b0010,1,0,2'd0);
      add(1,0,4'b0010,4'b0000,32'h00004200, 4'b0010,1,8'h42,4'b0010,1,0,2'd0);
      add(1,0,4'b0010,4'b0010,32'h00004300, 4'b0010,1,8'h43,4'b0010,1,0,2'd0);
      add(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      // backpressure for 10 cycles is not a stall
      add(1,0,4'b0100,4'b0000,32'h00E00000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      for (int i = 0; i < 10; i++)
         add(1,1,4'b0100,4'b0000,32'h00E00000, 4'b0100,0,8'hE0,4'b0000,1,0,2'd0);
      add(1,0,4'b0100,4'b0000,32'h00E00000, 4'b0100,1,8'hE0,4'b0100,1,0,2'd0);
      add(1,0,4'b0100,4'b0100,32'h00E10000, 4'b0100,1,8'hE1,4'b0100,1,0,2'd0);
      add(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      // req2 stalls after one byte; watchdog revokes, req3 is next
      add(1,0,4'b0100,4'b0000,32'h00F00000, 4'b0000,0,8'h00,4'b0000,0,0,2'd0);
      add(1,0,4'b0100,4'b0000,32'h00F00000, 4'b0100,1,8'hF0,4'b0100,1,0,2'd0);
      for (int i = 0; i < 4; i++)
         add(1,0,4'b1000,4'b1000,32'h50000000, 4'b0100,0,8'h00,4'b0100,1,0,2'd0);
      add(1,0,4'b1000,4'b1000,32'h50000000, 4'b0100,0,8'h00,4'b0000,1,0,2'd0);
      add(1,0,4'b1000,4'b1000,32'h50000000, 4'b0000,0,8'h00,4'b0000,0,1,2'd2);
      add(1,0,4'b1000,4'b1000,32'h50000000, 4'b1000,1,8'h50,4'b1000,1,0,2'd2);
      add(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);
      // en low during req0 frame: frame completes, req1 waits
      add(1,0,4'b0011,4'b0000,32'h00006170, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);
      add(0,0,4'b0011,4'b0000,32'h00006170, 4'b0001,1,8'h70,4'b0001,1,0,2'd2);
      add(0,0,4'b0011,4'b0001,32'h00006171, 4'b0001,1,8'h71,4'b0001,1,0,2'd2);
      add(0,0,4'b0010,4'b0000,32'h00006100, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);
      add(0,0,4'b0010,4'b0000,32'h00006100, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);
      add(1,0,4'b0010,4'b0010,32'h00006100, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);
      add(1,0,4'b0010,4'b0010,32'h00006100, 4'b0010,1,8'h61,4'b0010,1,0,2'd2);
      add(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,4'b0000,0,0,2'd2);

      rst_n = 1'b0; en = 1'b1; valid = 4'b1111; last = 4'b0000; data = 32'hAABBCCDD; full = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_all("reset", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 2'd0);
      valid = 4'b0000; data = '0;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         en = vecs[i].en; full = vecs[i].full; valid = vecs[i].valid;
         last = vecs[i].last; data = vecs[i].data;
         #1 chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].push, vecs[i].dat,
                    vecs[i].rdy, vecs[i].busy, vecs[i].to, vecs[i].toid);
      end

      // asynchronous reset mid-frame, then reset pointer favours req0 over req3
      @(negedge clk);
      en = 1'b1; full = 1'b0; valid = 4'b1000; last = 4'b0000; data = 32'h55000000;
      #1 chk_all("pre_rst idle", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 2'd2);
      @(negedge clk);
      #1 chk_all("pre_rst burst", 4'b1000, 1, 8'h55, 4'b1000, 1, 0, 2'd2);
      #1 rst_n = 1'b0;
      #1 chk_all("mid_rst", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1; valid = 4'b1001; last = 4'b0001; data = 32'h55000077;
      #1 chk_all("post_rst idle", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 2'd0);
      @(negedge clk);
      #1 chk_all("post_rst grant0", 4'b0001, 1, 8'h77, 4'b0001, 1, 0, 2'd0);
      @(negedge clk);
      valid = 4'b0000; last = 4'b0000; data = '0;
      #1 chk_all("post_rst done", 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Frame-atomic round-robin scheduler that shares the single UART transmit FIFO push port between `NUM_REQ` byte-stream requesters (CPU shim, DMA channels, debug console). It sits between the requesters and the TX FIFO write side (`push`/`full`) of the APB4 UART. Once a requester is granted, it keeps the FIFO until it delivers its `last` byte, so frames never interleave on the wire. A per-grant stall watchdog reclaims the port from a requester that stops mid-frame.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, byte width, equals TX FIFO data width
- `TIMEOUT`, 255, consecutive requester-idle cycles in a granted frame before the grant is revoked (≥1)
- `ID_WIDTH`, `$clog2(NUM_REQ)`, requester index width
- `clk_i` in 1: clock; one clock domain
- `rst_n_i` in 1: reset, asynchronous, active-low
- `en_i` in 1: scheduler enable; gates new grants only
- `req_valid_i` in NUM_REQ: per-requester byte valid
- `req_data_i` in NUM_REQ*DATA_WIDTH: packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last_i` in NUM_REQ: byte is the final byte of the frame
- `req_ready_o` out NUM_REQ: per-requester byte accepted
- `push_o` out 1: TX FIFO push
- `dat_o` out DATA_WIDTH: TX FIFO write data
- `full_i` in 1: TX FIFO full
- `gnt_o` out NUM_REQ: one-hot current grant, 0 when idle
- `busy_o` out 1: a frame is in progress
- `timeout_o` out 1: one-cycle pulse on watchdog revoke
- `timeout_id_o` out ID_WIDTH: index of the revoked requester, held until the next revoke

## Operation
- FSM states: IDLE and BURST. Registers: state, `gnt_id`, `last_id` (round-robin pointer), stall counter, `timeout_id`.
- In IDLE, if `en_i`=1 and any `req_valid_i` bit is set, select the first valid index scanning `last_id+1, last_id+2, …` (mod NUM_REQ). Register it into `gnt_id` and go to BURST. No byte transfers in IDLE.
- BURST, with g = `gnt_id`:
  - `req_ready_o[g]` = ~`full_i`. All other ready bits are 0.
  - `push_o` = `req_valid_i[g]` & ~`full_i`.
  - `dat_o` = byte g. The path is combinational, with zero latency.
- Transfer occurs when `push_o`=1. If the transfer carries `req_last_i[g]`=1: `last_id`←g, go to IDLE.
- Stall counter:
  - Cleared on entry to BURST and on every transfer.
  - Increments on each BURST cycle with `req_valid_i[g]`=0.
  - Holds while `full_i`=1 and valid=1, because backpressure is not a stall.
- Watchdog: when the counter reaches TIMEOUT, pulse `timeout_o` in the next cycle, set `timeout_id`←g, `last_id`←g, and go to IDLE. The requester's partial frame is abandoned and no byte is pushed for it.
- `en_i`=0 in BURST does not abort. The current frame finishes and no new grant is issued afterwards.
- `gnt_o` = onehot(g) in BURST, 0 in IDLE. `busy_o` = (state==BURST).
- Reset values:
  - state IDLE, `gnt_id` 0, `last_id` NUM_REQ-1 (requester 0 first after reset), counter 0.
  - `timeout_o` 0, `timeout_id_o` 0, `gnt_o` 0, `busy_o` 0, `push_o` 0, all ready 0.
- Reset mid-frame drops the grant immediately. No push is issued in the reset cycle.
- A requester deasserting valid mid-frame is legal; only the watchdog ends such a frame.

## Timing
- Arbitration latency: a request seen in IDLE at cycle n gives a grant (`gnt_o`, ready) at n+1.
- An unstalled frame of L bytes occupies L+1 cycles (1 IDLE + L BURST).
- Back-to-back frames always have exactly one IDLE cycle between them.
- Last byte accepted at cycle n → IDLE at n+1 → next grant at n+2.
- Watchdog: last valid-low cycle counted at k (counter = TIMEOUT) → `timeout_o`=1 and IDLE at k+1.

## Structure
- `uart_sched_pkg`: state enum (`SCHED_IDLE`, `SCHED_BURST`) and the default NUM_REQ/TIMEOUT constants. Shared with the UART register block for the timeout status field.
- Sub-module `uart_rr_arb`: combinational round-robin pick. Inputs are the request vector and the pointer; outputs are the index and a found flag.
- Top level: FSM, counter, and output muxing.

## Test plan
- Reset, then req1 sends a 3-byte frame 0x41,0x42,0x43 (last on 0x43) → grant at cycle 1, three pushes in order, `busy_o` low after 4 cycles.
- req0, req2 and req3 all valid with 2-byte frames → grant order 0,2,3, one IDLE cycle between frames, no interleaved bytes.
- `full_i` held high 10 cycles mid-frame with TIMEOUT=4 → no push, no timeout. Frame completes after `full_i` drops.
- Granted req2 drops valid after 1 byte with TIMEOUT=4 → `timeout_o` pulses 5 cycles after the drop, `timeout_id_o`=2, next grant goes to req3 if valid.
- `en_i` dropped during req0's frame with req1 pending → req0 frame completes, req1 is not granted until `en_i`=1.
- `rst_n_i` asserted mid-frame → outputs zero asynchronously. After release, req0 wins over req3 when both are valid.
